// File: rtl/register_scoreboard_pkg.sv
// register_scoreboard_pkg: shared FSM encodings and defaults for the register scoreboard
package register_scoreboard_pkg;
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DRAIN    = 2'd1,
        CSR_BUSY = 2'd2
    } state_t;
    localparam int MAX_OUTSTANDING_DEFAULT = 4;
    localparam logic ENABLE = 1'b1;
    localparam logic DISABLE = 1'b0;
endpackage

// File: rtl/register_scoreboard_outstanding_counter.sv
// register_scoreboard_outstanding_counter: saturating up/down counter; simultaneous inc and dec cancel
module register_scoreboard_outstanding_counter #(
    parameter int MAX_COUNT = 4,
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             dec,
    output logic [WIDTH-1:0] count
);
    always_ff @(posedge clk) begin
        if (!reset)
            count <= '0;
        else if (inc && !dec && count != WIDTH'(MAX_COUNT))
            count <= count + 1'b1;
        else if (dec && !inc && count != '0)
            count <= count - 1'b1;
    end
endmodule

// File: rtl/register_scoreboard.sv
// register_scoreboard: RAW/WAW hazard tracking for long-latency writes with CSR serialization
module register_scoreboard
    import register_scoreboard_pkg::*;
#(
    parameter int MAX_OUTSTANDING = MAX_OUTSTANDING_DEFAULT,
    parameter int COUNT_WIDTH = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   issue_valid,
    input  logic [4:0]             read_index_1,
    input  logic [4:0]             read_index_2,
    input  logic                   read_enable_1,
    input  logic                   read_enable_2,
    input  logic [4:0]             write_index,
    input  logic                   write_enable,
    input  logic                   long_latency,
    input  logic                   csr_access,
    input  logic                   writeback_valid,
    input  logic [4:0]             writeback_index,
    input  logic                   csr_done,
    output logic                   issue_ready,
    output logic [31:0]            pending_mask,
    output logic [COUNT_WIDTH-1:0] outstanding_count,
    output logic [1:0]             state
);
    state_t st;
    logic wb_hit, raw, waw, full, hazard_ok, issue, set_pend, drained;
    logic [31:0] clr_mask, set_mask, eff_pending;
    logic [COUNT_WIDTH-1:0] eff_count;

    // A completing writeback is bypassed so its dependents can issue in the same cycle
    always_comb begin
        wb_hit = writeback_valid && writeback_index != 5'd0 && pending_mask[writeback_index];
        clr_mask = wb_hit ? (32'd1 << writeback_index) : 32'd0;
        eff_pending = pending_mask & ~clr_mask;
        eff_count = outstanding_count - {{(COUNT_WIDTH-1){1'b0}}, wb_hit};
        drained = eff_count == '0;
        raw = (read_enable_1 && read_index_1 != 5'd0 && eff_pending[read_index_1]) ||
              (read_enable_2 && read_index_2 != 5'd0 && eff_pending[read_index_2]);
        waw = write_enable && write_index != 5'd0 && eff_pending[write_index];
        full = long_latency && write_enable && eff_count == COUNT_WIDTH'(MAX_OUTSTANDING);
        hazard_ok = !raw && !waw && !full;
        issue_ready = !reset ? DISABLE :
                      st == IDLE  ? hazard_ok && (!csr_access || drained) :
                      st == DRAIN ? hazard_ok && drained : DISABLE;
        issue = issue_valid && issue_ready;
        set_pend = issue && long_latency && write_enable && write_index != 5'd0;
        set_mask = set_pend ? (32'd1 << write_index) : 32'd0;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pending_mask <= '0;
            st <= IDLE;
        end else begin
            pending_mask <= eff_pending | set_mask;
            case (st)
                IDLE:     st <= !(issue_valid && csr_access) ? IDLE :
                                issue_ready ? CSR_BUSY : drained ? IDLE : DRAIN;
                DRAIN:    st <= !issue_valid ? IDLE : issue_ready ? CSR_BUSY : DRAIN;
                CSR_BUSY: st <= csr_done ? IDLE : CSR_BUSY;
                default:  st <= IDLE;
            endcase
        end
    end

    assign state = st;

    register_scoreboard_outstanding_counter #(
        .MAX_COUNT(MAX_OUTSTANDING),
        .WIDTH(COUNT_WIDTH)
    ) u_counter (
        .clk(clk),
        .reset(reset),
        .inc(set_pend),
        .dec(wb_hit),
        .count(outstanding_count)
    );
endmodule

// File: doc/register_scoreboard.md
REGISTER_SCOREBOARD -- requirements
Module: Register_Scoreboard

Interface
REQ-001 SHALL have parameter MAX_OUTSTANDING, default 4, meaning the maximum number of in-flight long-latency register writes.
REQ-002 SHALL have parameter COUNT_WIDTH, default 3, meaning the counter width; it equals clog2(MAX_OUTSTANDING+1).
REQ-003 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-004 SHALL have port reset, input, 1 bit: reset, synchronous, active-low.
REQ-005 SHALL have port issue_valid, input, 1 bit: a decoded instruction is presented for issue.
REQ-006 SHALL have ports read_index_1 and read_index_2, input, 5 bits each, with read_enable_1 and read_enable_2, input, 1 bit each: the source registers.
REQ-007 SHALL have ports write_index, input, 5 bits, and write_enable, input, 1 bit: the destination register.
REQ-008 SHALL have port long_latency, input, 1 bit: the destination is written back later, as for load, mul or div.
REQ-009 SHALL have port csr_access, input, 1 bit: the instruction is a CSR read or write and must be serialized.
REQ-010 SHALL have ports writeback_valid, input, 1 bit, and writeback_index, input, 5 bits: long-latency completion.
REQ-011 SHALL have port csr_done, input, 1 bit: the CSR unit has finished the in-flight CSR operation.
REQ-012 SHALL have port issue_ready, output, 1 bit, combinational: the instruction issues when issue_valid and issue_ready are both 1.
REQ-013 SHALL have ports pending_mask, output, 32 bits, outstanding_count, output, COUNT_WIDTH bits, and state, output, 2 bits, all registered.

Function
REQ-014 SHALL hold one pending bit per register; bit 0 is never set.
REQ-015 SHALL apply effective pending = pending_mask with the bit cleared for a valid writeback to a pending register in the same cycle; the clear is bypassed into hazard checks.
REQ-016 SHALL deassert issue_ready on RAW: an enabled source register is effective-pending and the index is not 0.
REQ-017 SHALL deassert issue_ready on WAW: write_enable is 1, write_index is not 0, and the destination is effective-pending.
REQ-018 SHALL deassert issue_ready when long_latency=1 and write_enable=1 and the effective count equals MAX_OUTSTANDING. The effective count is the count minus a same-cycle valid decrement.
REQ-019 SHALL, on issue with long_latency=1, write_enable=1 and write_index not 0, set pending[write_index] and increment the count. Set wins over a same-cycle clear of the same bit.
REQ-020 SHALL leave pending bits and the count unchanged for short-latency writes.
REQ-021 SHALL, on writeback_valid to a pending register, clear the bit and decrement the count. A writeback to a non-pending register or to register 0 is ignored.
REQ-022 SHALL give the count a net change of 0 when a writeback decrement and an issue increment occur in the same cycle.
REQ-023 SHALL have FSM states IDLE=0, DRAIN=1, CSR_BUSY=2.
REQ-024 SHALL, in IDLE, when issue_valid=1, csr_access=1 and the effective count is not 0: hold issue_ready=0 and go to DRAIN.
REQ-025 SHALL, in IDLE, issue a CSR instruction when the effective count is 0 and REQ-016/017 pass, then go to CSR_BUSY.
REQ-026 SHALL, in DRAIN, hold issue_ready=0 until the effective count is 0. The CSR then issues and the FSM goes to CSR_BUSY.
REQ-027 SHALL, in DRAIN, return to IDLE when issue_valid=0 (flush).
REQ-028 SHALL, in CSR_BUSY, hold issue_ready=0 and return to IDLE on csr_done. issue_ready may rise in the cycle after csr_done.
REQ-029 SHALL ignore csr_done outside CSR_BUSY.
REQ-030 SHALL continue to process writebacks in every state.
REQ-031 SHALL treat state encoding 3 as IDLE on the next edge.

Reset
REQ-032 SHALL, while reset=0 at the clock edge, set pending_mask=0, outstanding_count=0 and state=IDLE.
REQ-033 SHALL hold issue_ready=0 while reset=0.
REQ-034 SHALL discard an issue or writeback presented in a reset cycle.
REQ-035 SHALL abandon an in-flight CSR wait on reset mid-operation; the FSM is in IDLE after reset.

Structure
REQ-036 SHALL place the state encodings, MAX_OUTSTANDING default, ENABLE and DISABLE in the shared Defines.v.
REQ-037 SHALL use one sub-module, Outstanding_Counter, a saturating up/down counter with simultaneous inc/dec; all other logic is inline.

Verification
REQ-038 SHALL cover: issue lw x5 (long) then add x6,x5,x1 -> issue_ready=0 until writeback x5; same-cycle bypass -> add issues in the writeback cycle.
REQ-039 SHALL cover: 4 long ops to x1..x4 then a 5th to x7 -> issue_ready=0 with count=4; writeback x2 -> the 5th issues that cycle; count stays 4.
REQ-040 SHALL cover: csrrw with x3 pending -> state=DRAIN, issue_ready=0; writeback x3 -> CSR issues, state=CSR_BUSY; csr_done -> IDLE, issue_ready=1 the next cycle.
REQ-041 SHALL cover: long op to x0 -> pending_mask=0 and count=0; writeback x9 not pending -> no change.
REQ-042 SHALL cover: reset=0 asserted in CSR_BUSY with count=2 -> next cycle state=IDLE, count=0, pending_mask=0.
REQ-043 SHALL cover: in DRAIN, issue_valid dropped -> IDLE next cycle; pending bits retained.
